// File: rtl/demux_4_buf.sv
// demux_4_buf
// Buffered 1-to-4 demultiplexer. A single producer stream, tagged with a
// 2-bit lane select, is steered into one of four independent lanes. Each
// lane is a 2-entry circular FIFO, so a stalled consumer on one lane never
// blocks or corrupts the other three.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset, clears all lanes
//   in_data    - input word (N bits)
//   in_sel     - destination lane 0..3
//   in_valid   - producer offers in_data/in_sel
//   in_ready   - the selected lane has room this cycle
//   out_data   - lane k head word at bits [k*N +: N]
//   out_valid  - bit k set when lane k holds data
//   out_ready  - bit k set when the lane k consumer accepts
//   occupancy  - lane k entry count (0..2) at bits [2k +: 2]
module demux_4_buf #(
    parameter int N = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4*N-1:0]   out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       occupancy
);

    // Per-lane state: two storage slots, write/read pointers, entry count.
    logic [3:0][1:0][N-1:0] mem_q, mem_d;
    logic [3:0]             wr_ptr_q, wr_ptr_d;
    logic [3:0]             rd_ptr_q, rd_ptr_d;
    logic [3:0][1:0]        count_q, count_d;

    logic push;

    // in_ready looks only at the registered count of the selected lane, so a
    // full lane is refused even if it pops this cycle. That keeps out_ready
    // off every path into in_ready.
    always_comb begin
        in_ready  = (count_q[in_sel] != 2'd2);
        out_valid = '0;
        out_data  = '0;
        occupancy = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]          = (count_q[k] != 2'd0);
            out_data[k*N +: N]    = mem_q[k][rd_ptr_q[k]];
            occupancy[2*k +: 2]   = count_q[k];
        end
    end

    assign push = in_valid && in_ready;

    // Next-state for every lane. A simultaneous push and pop advances both
    // pointers and leaves the count alone, which gives one word per cycle of
    // throughput with a single entry resident.
    always_comb begin
        logic lane_push;
        logic lane_pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        lane_push = 1'b0;
        lane_pop  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lane_push = push && (in_sel == 2'(k));
            lane_pop  = out_valid[k] && out_ready[k];
            if (lane_push) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            if (lane_pop) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            unique case ({lane_push, lane_pop})
                2'b10:   count_d[k] = count_q[k] + 2'd1;
                2'b01:   count_d[k] = count_q[k] - 2'd1;
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    // State register. Reset wipes storage as well so that stale words can
    // never reappear on out_data after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
